frame_capture: RTL

- Receive-side counterpart of camera_control. Sits between the 2-row pixel sensor/ADC and downstream logic.
- Observes the controller's expose/erase/nre1/nre2/adc strobes and captures each row's digitised column data when it is read out.
- Buffers one complete frame and streams it out pixel-by-pixel over a valid/ready handshake.
- Flags protocol violations and frame overruns.

---
 rtl/frame_capture.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/frame_capture.sv
// Receive-side frame buffer for the 2-row sensor: captures each row's ADC data when the
// camera controller strobes it, then streams the frame pixel-by-pixel over valid/ready.
module frame_capture #(
    parameter int unsigned SIZE  = 2,
    parameter int unsigned ADC_W = 8,
    localparam int unsigned COL_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  expose,
    input  logic                  erase,
    input  logic                  nre1,
    input  logic                  nre2,
    input  logic                  adc,
    input  logic [SIZE*ADC_W-1:0] col_data,
    input  logic                  out_ready,
    output logic [ADC_W-1:0]      pix_out,
    output logic                  pix_valid,
    output logic                  pix_row,
    output logic [COL_W-1:0]      pix_col,
    output logic                  frame_done,
    output logic                  proto_err,
    output logic                  overrun
);

    typedef enum logic [1:0] {StIdle, StArmed, StStream} state_e;

    state_e           state_q, state_d;
    logic [1:0]       row_mask_q, row_mask_d;
    logic [ADC_W-1:0] mem_q [2][SIZE];
    logic [ADC_W-1:0] mem_d [2][SIZE];
    logic             adc_prev_q, expose_prev_q;
    logic [ADC_W-1:0] pix_out_q, pix_out_d;
    logic             pix_row_q, pix_row_d;
    logic [COL_W-1:0] pix_col_q, pix_col_d;
    logic             frame_done_q, frame_done_d;
    logic             proto_err_q, proto_err_d;
    logic             overrun_q, overrun_d;

    logic             adc_rise, expose_rise;
    logic             cap_row;
    logic             last_pix;
    logic             nxt_row;
    logic [COL_W-1:0] nxt_col;

    assign adc_rise    = adc & ~adc_prev_q;
    assign expose_rise = expose & ~expose_prev_q;
    // nre1 low selects row 0; only meaningful when exactly one enable is low
    assign cap_row     = nre1;
    assign last_pix    = pix_row_q && (pix_col_q == COL_W'(SIZE - 1));

    // Pixel order: row 0 cols 0..SIZE-1, then row 1
    always_comb begin
        if (pix_col_q == COL_W'(SIZE - 1)) begin
            nxt_col = '0;
            nxt_row = 1'b1;
        end else begin
            nxt_col = pix_col_q + 1'b1;
            nxt_row = pix_row_q;
        end
    end

    // Next-state: capture control, streaming sequencer and sticky error flags
    always_comb begin
        state_d      = state_q;
        row_mask_d   = row_mask_q;
        mem_d        = mem_q;
        pix_out_d    = pix_out_q;
        pix_row_d    = pix_row_q;
        pix_col_d    = pix_col_q;
        frame_done_d = 1'b0;
        proto_err_d  = proto_err_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (expose_rise) begin
                    state_d    = StArmed;
                    row_mask_d = 2'b00;
                end
            end
            StArmed: begin
                // erase wins over a same-cycle adc strobe
                if (erase) begin
                    state_d    = StIdle;
                    row_mask_d = 2'b00;
                end else if (row_mask_q == 2'b11) begin
                    state_d   = StStream;
                    pix_row_d = 1'b0;
                    pix_col_d = '0;
                    pix_out_d = mem_q[0][0];
                end else if (adc_rise) begin
                    if (nre1 != nre2) begin
                        for (int c = 0; c < SIZE; c++) begin
                            mem_d[cap_row][c] = col_data[c*ADC_W +: ADC_W];
                        end
                        row_mask_d[cap_row] = 1'b1;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            StStream: begin
                if (expose_rise) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (last_pix) begin
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                        pix_row_d    = 1'b0;
                        pix_col_d    = '0;
                    end else begin
                        pix_row_d = nxt_row;
                        pix_col_d = nxt_col;
                        pix_out_d = mem_q[nxt_row][nxt_col];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            row_mask_q    <= 2'b00;
            adc_prev_q    <= 1'b0;
            expose_prev_q <= 1'b0;
            pix_out_q     <= '0;
            pix_row_q     <= 1'b0;
            pix_col_q     <= '0;
            frame_done_q  <= 1'b0;
            proto_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            row_mask_q    <= row_mask_d;
            adc_prev_q    <= adc;
            expose_prev_q <= expose;
            pix_out_q     <= pix_out_d;
            pix_row_q     <= pix_row_d;
            pix_col_q     <= pix_col_d;
            frame_done_q  <= frame_done_d;
            proto_err_q   <= proto_err_d;
            overrun_q     <= overrun_d;
            mem_q         <= mem_d;
        end
    end

    assign pix_out    = pix_out_q;
    assign pix_valid  = (state_q == StStream);
    assign pix_row    = pix_row_q;
    assign pix_col    = pix_col_q;
    assign frame_done = frame_done_q;
    assign proto_err  = proto_err_q;
    assign overrun    = overrun_q;

endmodule
